// File: rtl/serial_pkg.sv
// Shared FSM state type and width constants for the MSB-first operand serializer.
// No logic; consumed via import serial_pkg::*.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must hold WIDTH-1; a 1-bit counter still covers WIDTH=2.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_shift_reg_msb.sv
// Parallel-load, shift-left register exposing its MSB; load wins over shift.
// Zeros shift in, so the register drains to 0 after WIDTH shifts; no backpressure of its own.
module serial_shift_reg_msb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= data;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/serial_operand_serializer_msb_first.sv
// Serializes an A/B operand pair MSB first with first/last framing; 1-cycle accept-to-MSB latency.
// SERIALIZER_BACKPRESSURE_EN adds out_ready to stall bits; otherwise every valid cycle advances.
module serial_operand_serializer_msb_first
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
`ifdef SERIALIZER_BACKPRESSURE_EN
    input  logic             out_ready,
`endif
    output logic             out_a,
    output logic             out_b,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last
);

    localparam int            CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          out_valid_nxt, first_nxt, last_nxt;
    logic          ready_eff, advance, accept, at_lsb, shift;

`ifdef SERIALIZER_BACKPRESSURE_EN
    assign ready_eff = out_ready;
`else
    assign ready_eff = 1'b1;
`endif

    assign advance  = out_valid & ready_eff;
    assign at_lsb   = (state == SHIFT) && (cnt == '0);
    assign in_ready = (state == IDLE) | (at_lsb & ready_eff);
    assign accept   = in_valid & in_ready;
    // A reload in the LSB cycle replaces the shift; otherwise zeros drain in.
    assign shift    = advance & ~accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        out_valid_nxt = out_valid;
        first_nxt     = out_first;
        last_nxt      = out_last;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt     = SHIFT;
                    cnt_nxt       = CNT_MAX;
                    out_valid_nxt = 1'b1;
                    first_nxt     = 1'b1;
                    last_nxt      = 1'b0;
                end
            end
            SHIFT: begin
                if (advance) begin
                    if (accept) begin
                        cnt_nxt   = CNT_MAX;
                        first_nxt = 1'b1;
                        last_nxt  = 1'b0;
                    end else if (cnt == '0) begin
                        state_nxt     = IDLE;
                        out_valid_nxt = 1'b0;
                        first_nxt     = 1'b0;
                        last_nxt      = 1'b0;
                    end else begin
                        cnt_nxt   = cnt - CNT_ONE;
                        first_nxt = 1'b0;
                        last_nxt  = (cnt == CNT_ONE);
                    end
                end
            end
            default: begin
                state_nxt     = IDLE;
                cnt_nxt       = '0;
                out_valid_nxt = 1'b0;
                first_nxt     = 1'b0;
                last_nxt      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            out_valid <= out_valid_nxt;
            out_first <= first_nxt;
            out_last  <= last_nxt;
        end
    end

    serial_shift_reg_msb #(.WIDTH(WIDTH)) u_sr_a (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift),
        .data  (in_a),
        .msb   (out_a)
    );

    serial_shift_reg_msb #(.WIDTH(WIDTH)) u_sr_b (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift),
        .data  (in_b),
        .msb   (out_b)
    );

endmodule

// File: doc/serial_operand_serializer_msb_first.md
SERIAL_OPERAND_SERIALIZER_MSB_FIRST -- requirements
Module: serial_operand_serializer_msb_first

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  parallel operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  block accepts the pair this cycle.
REQ-006 SHALL have ports: in_a and in_b, each input, WIDTH bits, parallel operands A and B.
REQ-007 SHALL have ports: out_a and out_b, each output, 1 bit, current serial bit of A and B, MSB first.
REQ-008 SHALL have port: out_valid  output  1  out_a/out_b carry a valid bit.
REQ-009 SHALL have port: out_first  output  1  high with the MSB of each frame; drives a downstream serial comparator's restart.
REQ-010 SHALL have port: out_last  output  1  high with the LSB of each frame.

Function
REQ-011 SHALL implement FSM states IDLE and SHIFT.
REQ-012 SHALL drive in_ready high in IDLE, and in SHIFT only during the cycle the LSB is presented and advancing.
REQ-013 SHALL accept a pair when in_valid && in_ready, capturing in_a and in_b into shift registers and loading the bit counter with WIDTH-1.
REQ-014 SHALL present bit WIDTH-1 (MSB) on the cycle after acceptance, with out_valid=1 and out_first=1; latency is 1 cycle.
REQ-015 SHALL present one bit per advancing cycle, in order WIDTH-1 down to 0, on exactly WIDTH consecutive advancing cycles.
REQ-016 SHALL assert out_last only when the counter equals 0; out_first and out_last are never high together, because WIDTH>=2.
REQ-017 SHALL, on acceptance in the LSB cycle, output the next frame's MSB on the following cycle with no bubble and remain in SHIFT.
REQ-018 SHALL, when the LSB advances with no new acceptance, return to IDLE with out_valid=0 on the next cycle.
REQ-019 SHALL ignore in_a and in_b changes while in_ready=0; captured data is held until the frame completes.
REQ-020 SHALL drive out_a, out_b, out_first and out_last to 0 whenever out_valid=0.
REQ-021 SHALL drive all outputs from flops, except in_ready, which is combinational from state, counter and out_ready.

Reset
REQ-022 SHALL, while rst=0, force state IDLE, counter 0, shift registers 0, out_valid/out_a/out_b/out_first/out_last=0, and in_ready=1 after release.
REQ-023 SHALL abort any frame in progress on reset mid-frame; no partial bits are emitted after release.
REQ-024 SHALL accept a new pair on the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL support the macro SERIALIZER_BACKPRESSURE_EN.
REQ-026 With SERIALIZER_BACKPRESSURE_EN defined, SHALL add port out_ready (input, 1 bit); a bit advances only when out_valid && out_ready; while out_ready=0, all outputs, the counter and the state SHALL hold; in_ready in the LSB cycle additionally requires out_ready=1.
REQ-027 Without SERIALIZER_BACKPRESSURE_EN, SHALL omit port out_ready, and every out_valid cycle SHALL advance.

Structure
REQ-028 SHALL place the state enum (IDLE, SHIFT) and the default width constant in shared package serial_pkg.
REQ-029 SHALL instantiate two copies of sub-module serial_shift_reg_msb, one per operand, each with parallel load, shift-left enable and MSB tap; the counter and FSM stay in the top module.

Verification
REQ-030 Single frame, WIDTH=8: A=8'hA5, B=8'h3C, one in_valid pulse -> out_a=1,0,1,0,0,1,0,1 and out_b=0,0,1,1,1,1,0,0 on cycles 1..8 after acceptance; out_first at cycle 1, out_last at cycle 8, then IDLE.
REQ-031 Back-to-back: in_valid held high with A=8'hFF,B=8'h00 then A=8'h01,B=8'h80 -> 16 contiguous valid bits, second out_first immediately after the first out_last, in_ready pulses high once per frame.
REQ-032 Mid-frame reset: rst=0 after bit 3 of A=8'hF0 -> out_valid=0 during reset, no further frame-1 bits after release; next pair A=8'h0F serializes cleanly.
REQ-033 Input change while busy: drive in_a=8'h55 during SHIFT with in_valid=0 -> emitted frame unchanged from the captured value.
REQ-034 SERIALIZER_BACKPRESSURE_EN: A=8'hC3, out_ready=0 for 3 cycles at bit 5 -> out_a/out_b/out_first/out_last held stable for the stall; total frame = 8 advancing cycles; serial outputs fed to a MSB-first serial comparator yield a_greater_b when A=8'hC3, B=8'h3C.
REQ-035 Self-check: the bench reassembles out_a and out_b per frame and compares against the accepted A and B for 1000 random pairs with random in_valid gaps -> zero mismatches.
